// File: rtl/mem_arb_pkg.sv
// Shared types for the dual-core memory arbiter: RAM status codes, arbiter
// state, and the {cls, core} requester index.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    RAM_FREE   = 2'd0,
    RAM_BUSY   = 2'd1,
    RAM_ACCESS = 2'd2,
    RAM_ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  // cls = 1 selects the dcache of a core, cls = 0 its icache.
  typedef struct packed {
    logic cls;
    logic core;
  } req_idx_t;

  localparam int BURST_MAX_DEF = 4;

endpackage

// File: rtl/arb_pick.sv
// Rotating-priority picker over the four requesters.
// Order from the round-robin pointer: d[rr], d[~rr], i[rr], i[~rr].
module arb_pick
  import mem_arb_pkg::*;
(
  input  logic [3:0] i_req,
  input  logic       i_rr,
  output req_idx_t   o_win,
  output logic       o_vld
);

  always_comb begin
    o_win = '0;
    o_vld = 1'b0;
    if (i_req[{1'b1, i_rr}]) begin
      o_win = '{cls: 1'b1, core: i_rr};
      o_vld = 1'b1;
    end else if (i_req[{1'b1, ~i_rr}]) begin
      o_win = '{cls: 1'b1, core: ~i_rr};
      o_vld = 1'b1;
    end else if (i_req[{1'b0, i_rr}]) begin
      o_win = '{cls: 1'b0, core: i_rr};
      o_vld = 1'b1;
    end else if (i_req[{1'b0, ~i_rr}]) begin
      o_win = '{cls: 1'b0, core: ~i_rr};
      o_vld = 1'b1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Single-ported RAM arbiter for two cores' icache/dcache pairs. Holds the
// grant across multi-word dcache sequences so WB/fill pairs never interleave.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int CPUS      = 2,
  parameter int BURST_MAX = BURST_MAX_DEF
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [CPUS-1:0]       iREN,
  input  logic [CPUS-1:0][31:0] iaddr,
  output logic [CPUS-1:0]       iwait,
  output logic [CPUS-1:0][31:0] iload,
  input  logic [CPUS-1:0]       dREN,
  input  logic [CPUS-1:0]       dWEN,
  input  logic [CPUS-1:0][31:0] daddr,
  input  logic [CPUS-1:0][31:0] dstore,
  output logic [CPUS-1:0]       dwait,
  output logic [CPUS-1:0][31:0] dload,
  output logic                  ramREN,
  output logic                  ramWEN,
  output logic [31:0]           ramaddr,
  output logic [31:0]           ramstore,
  input  logic [31:0]           ramload,
  input  logic [1:0]            ramstate,
  output logic                  err
);

  arb_state_t r_state;
  req_idx_t   r_gnt;
  logic [2:0] r_cnt;
  logic       r_rr;
  logic       r_err;

  logic [CPUS-1:0] w_dreq;
  logic [3:0]      w_req;
  req_idx_t        w_pick;
  logic            w_pick_vld;
  logic            w_granted;
  logic            w_greq;
  logic            w_ram_done;
  logic            w_done;
  logic [2:0]      w_limit;
  logic [2:0]      w_cnt_nxt;
  logic            w_release;
  ramstate_t       w_rs;

  assign w_rs   = ramstate_t'(ramstate);
  assign w_dreq = dREN | dWEN;
  assign w_req  = {w_dreq[1:0], iREN[1:0]};

  arb_pick u_pick (
    .i_req (w_req),
    .i_rr  (r_rr),
    .o_win (w_pick),
    .o_vld (w_pick_vld)
  );

  assign w_granted  = (r_state == GRANT);
  assign w_greq     = r_gnt.cls ? w_dreq[r_gnt.core] : iREN[r_gnt.core];
  assign w_ram_done = (w_rs == RAM_ACCESS) || (w_rs == RAM_ERROR);
  // A reset cycle never reports a completion, even if the RAM answers.
  assign w_done     = w_granted && w_greq && w_ram_done && !RST;

  // icache grants are single-word; dcache grants may run to BURST_MAX.
  assign w_limit   = r_gnt.cls ? 3'(BURST_MAX) : 3'd1;
  assign w_cnt_nxt = (r_cnt >= 3'(BURST_MAX)) ? r_cnt : r_cnt + 3'd1;
  assign w_release = w_granted && (!w_greq || (w_done && (w_cnt_nxt >= w_limit)));

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= IDLE;
      r_gnt   <= '0;
      r_cnt   <= 3'd0;
      r_rr    <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_pick_vld) begin
            r_gnt   <= w_pick;
            r_cnt   <= 3'd0;
            r_state <= GRANT;
          end
        end
        GRANT: begin
          if (w_done) begin
            r_cnt <= w_cnt_nxt;
            if (w_rs == RAM_ERROR) r_err <= 1'b1;
          end
          if (w_release) begin
            r_state <= IDLE;
            r_rr    <= ~r_gnt.core;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // RAM mux follows the live inputs of the granted port.
  always_comb begin
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    iwait    = '1;
    dwait    = '1;
    if (w_granted) begin
      if (r_gnt.cls) begin
        ramWEN   = dWEN[r_gnt.core];
        ramREN   = dREN[r_gnt.core] & ~dWEN[r_gnt.core];
        ramaddr  = daddr[r_gnt.core];
        ramstore = dstore[r_gnt.core];
        if (w_done) dwait[r_gnt.core] = 1'b0;
      end else begin
        ramREN  = iREN[r_gnt.core];
        ramaddr = iaddr[r_gnt.core];
        if (w_done) iwait[r_gnt.core] = 1'b0;
      end
    end
  end

  assign iload = {CPUS{ramload}};
  assign dload = {CPUS{ramload}};
  assign err   = r_err;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: an owner/word-count model checks every
// cycle, and literal expectations pin the documented scenarios.
module tb_mem_arbiter;

  localparam int BURST = 4;

  logic             CLK;
  logic             RST;
  logic [1:0]       iREN;
  logic [1:0][31:0] iaddr;
  logic [1:0]       iwait;
  logic [1:0][31:0] iload;
  logic [1:0]       dREN;
  logic [1:0]       dWEN;
  logic [1:0][31:0] daddr;
  logic [1:0][31:0] dstore;
  logic [1:0]       dwait;
  logic [1:0][31:0] dload;
  logic             ramREN;
  logic             ramWEN;
  logic [31:0]      ramaddr;
  logic [31:0]      ramstore;
  logic [31:0]      ramload;
  logic [1:0]       ramstate;
  logic             err;

  mem_arbiter #(.CPUS(2), .BURST_MAX(BURST)) dut (
    .CLK(CLK), .RST(RST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate), .err(err)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: owner -1 means no grant; requester p = 2*cls + core.
  int  m_owner = -1;
  int  m_words = 0;
  int  m_rr    = 0;
  bit  m_err   = 0;
  bit  m_on    = 0;
  bit  m_done;
  logic [32:0] acc_log[$];

  function automatic bit wants(input int p);
    if (p >= 2) return dREN[p-2] | dWEN[p-2];
    return iREN[p];
  endfunction

  always @(negedge CLK) begin
    logic [1:0]  ew_i, ew_d;
    logic        eren, ewen;
    logic [31:0] eaddr, estore;
    int          core;
    bit          isd;
    bit          rel;
    int          order[4];
    ew_i = 2'b11; ew_d = 2'b11; eren = 0; ewen = 0; eaddr = 0; estore = 0;
    m_done = 0; isd = 0; core = 0;
    if (m_owner >= 0) begin
      isd  = (m_owner >= 2);
      core = m_owner % 2;
      if (isd) begin
        ewen   = dWEN[core];
        eren   = dREN[core] && !dWEN[core];
        eaddr  = daddr[core];
        estore = dstore[core];
      end else begin
        eren  = iREN[core];
        eaddr = iaddr[core];
      end
      m_done = wants(m_owner) && (ramstate == 2'd2 || ramstate == 2'd3) && !RST;
      if (m_done) begin
        if (isd) ew_d[core] = 1'b0;
        else     ew_i[core] = 1'b0;
      end
    end
    if (m_on) begin
      chk("m_iwait", iwait, ew_i);
      chk("m_dwait", dwait, ew_d);
      chk("m_ramREN", ramREN, eren);
      chk("m_ramWEN", ramWEN, ewen);
      chk("m_ramaddr", ramaddr, eaddr);
      if (m_owner < 0 || isd) chk("m_ramstore", ramstore, estore);
      chk("m_err", err, m_err);
      chk("m_iload", iload, {2{ramload}});
      chk("m_dload", dload, {2{ramload}});
      if ((ramREN || ramWEN) && (ramstate == 2'd2 || ramstate == 2'd3) && !RST)
        acc_log.push_back({ramWEN, ramaddr});
    end
    if (RST) begin
      m_owner = -1; m_words = 0; m_rr = 0; m_err = 0; m_on = 1;
    end else if (m_on) begin
      if (m_owner < 0) begin
        order = '{2 + m_rr, 3 - m_rr, m_rr, 1 - m_rr};
        for (int k = 0; k < 4; k++) begin
          if (m_owner < 0 && wants(order[k])) begin
            m_owner = order[k];
            m_words = 0;
          end
        end
      end else begin
        rel = 0;
        if (!wants(m_owner)) rel = 1;
        else if (m_done) begin
          m_words++;
          if (ramstate == 2'd3) m_err = 1;
          if (m_words >= ((m_owner >= 2) ? BURST : 1)) rel = 1;
        end
        if (rel) begin
          m_rr    = 1 - (m_owner % 2);
          m_owner = -1;
        end
      end
    end
  end

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk_log(input string nm, input logic [32:0] exp[], input int n);
    chk({nm, "_len"}, acc_log.size(), n);
    for (int k = 0; k < n && k < acc_log.size(); k++)
      chk(nm, acc_log[k], exp[k]);
  endtask

  initial begin
    logic [32:0] exp3[];
    logic [32:0] exp4[];
    RST = 1; iREN = 0; iaddr = '0; dREN = 0; dWEN = 0; daddr = '0; dstore = '0;
    ramload = 0; ramstate = 2'd0;

    // Reset then idle
    cyc(); cyc();
    RST = 0;
    @(negedge CLK);
    chk("rst_iwait", iwait, 2'b11);
    chk("rst_dwait", dwait, 2'b11);
    chk("rst_strobes", {ramREN, ramWEN}, 2'b00);
    chk("rst_err", err, 0);
    chk("rst_addr", ramaddr, 0);

    // Single icache read
    cyc();
    ramstate = 2'd2; ramload = 32'hDEADBEEF; iREN = 2'b01; iaddr[0] = 32'h40;
    @(negedge CLK);
    chk("i_t0_ren", ramREN, 0);
    cyc();
    @(negedge CLK);
    chk("i_t1_ren", ramREN, 1);
    chk("i_t1_addr", ramaddr, 32'h40);
    chk("i_t1_iwait", iwait, 2'b10);
    chk("i_t1_iload", iload[0], 32'hDEADBEEF);
    cyc();
    @(negedge CLK);
    chk("i_t2_idle", ramREN, 0);
    chk("i_t2_iwait", iwait, 2'b11);
    cyc();
    iREN = 2'b00;
    cyc();

    // dcache write-back + fill on core 1 with icache 0 pending
    acc_log.delete();
    dWEN = 2'b10; daddr[1] = 32'h100; dstore[1] = 32'h11111111;
    iREN = 2'b01; iaddr[0] = 32'h80;
    @(negedge CLK); chk("wb_iw0", iwait[0], 1);
    cyc(); @(negedge CLK); chk("wb_iw0", iwait[0], 1); chk("wb1_wen", ramWEN, 1);
    cyc(); daddr[1] = 32'h104; dstore[1] = 32'h22222222;
    @(negedge CLK); chk("wb_iw0", iwait[0], 1); chk("wb2_store", ramstore, 32'h22222222);
    cyc(); dWEN = 2'b00; dREN = 2'b10; daddr[1] = 32'h200;
    @(negedge CLK); chk("wb_iw0", iwait[0], 1); chk("ld1_ren", ramREN, 1);
    cyc(); daddr[1] = 32'h204;
    @(negedge CLK); chk("wb_iw0", iwait[0], 1); chk("ld2_dwait", dwait, 2'b01);
    cyc(); dREN = 2'b00;
    @(negedge CLK); chk("wb_gap", {ramREN, ramWEN}, 2'b00); chk("wb_iw0", iwait[0], 1);
    cyc();
    @(negedge CLK); chk("wb_i_addr", ramaddr, 32'h80); chk("wb_i_iwait", iwait, 2'b10);
    cyc(); iREN = 2'b00;
    cyc();
    exp3 = new[5];
    exp3[0] = {1'b1, 32'h100}; exp3[1] = {1'b1, 32'h104};
    exp3[2] = {1'b0, 32'h200}; exp3[3] = {1'b0, 32'h204}; exp3[4] = {1'b0, 32'h80};
    chk_log("wb_log", exp3, 5);

    // Contention between dcaches, rr = 0 after reset
    RST = 1; cyc(); RST = 0;
    acc_log.delete();
    dREN = 2'b11; daddr[0] = 32'h300; daddr[1] = 32'h400;
    cyc(); @(negedge CLK); chk("ct_d0", dwait, 2'b10);
    cyc(); daddr[0] = 32'h304;
    @(negedge CLK); chk("ct_d0b", dwait, 2'b10);
    cyc(); dREN = 2'b10;
    @(negedge CLK); chk("ct_rel", ramREN, 0);
    cyc(); @(negedge CLK); chk("ct_idle", ramREN, 0);
    cyc(); @(negedge CLK); chk("ct_d1", dwait, 2'b01); chk("ct_d1_addr", ramaddr, 32'h400);
    cyc(); daddr[1] = 32'h404;
    cyc(); dREN = 2'b00;
    cyc();
    exp4 = new[4];
    exp4[0] = {1'b0, 32'h300}; exp4[1] = {1'b0, 32'h304};
    exp4[2] = {1'b0, 32'h400}; exp4[3] = {1'b0, 32'h404};
    chk_log("ct_log", exp4, 4);

    // RAM busy for 3 cycles
    ramstate = 2'd1; dREN = 2'b01; daddr[0] = 32'h500;
    for (int k = 0; k < 3; k++) begin
      cyc(); @(negedge CLK);
      chk("busy_dwait", dwait[0], 1);
      chk("busy_ren", ramREN, 1);
      chk("busy_addr", ramaddr, 32'h500);
    end
    cyc(); ramstate = 2'd2;
    @(negedge CLK); chk("busy_done", dwait[0], 0); chk("busy_ren4", ramREN, 1);
    cyc(); dREN = 2'b00;
    cyc();

    // RAM error, then reset mid-grant
    ramstate = 2'd3; dREN = 2'b10; daddr[1] = 32'h600;
    @(negedge CLK); chk("er_t0_err", err, 0);
    cyc(); @(negedge CLK); chk("er_t1_dwait", dwait[1], 0); chk("er_t1_err", err, 0);
    cyc(); ramstate = 2'd1;
    @(negedge CLK); chk("er_t2_err", err, 1); chk("er_t2_dwait", dwait[1], 1);
    cyc(); RST = 1; ramstate = 2'd2;
    @(negedge CLK); chk("er_rst_nodone", dwait[1], 1); chk("er_t3_err", err, 1);
    cyc(); RST = 0;
    @(negedge CLK); chk("er_t4_ren", ramREN, 0); chk("er_t4_err", err, 0);
    cyc(); @(negedge CLK); chk("er_t5_regrant", dwait[1], 0); chk("er_t5_addr", ramaddr, 32'h600);
    cyc(); dREN = 2'b00;
    cyc(); cyc();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
